aes_axis_bridge: RTL
====================

# aes_axis_bridge

Stream-to-core bridge that sits directly upstream and downstream of `aes_top`. It collects a 32-bit AXI-Stream command frame into the `aes_cmd`/`aes_key`/`aes_plaintext` bus and fires a single-cycle `en` pulse. It then waits for `en_o`, captures `aes_ciphertext` and streams it back as four 32-bit words. It serialises all traffic, with one AES operation in flight at a time.

## Interface
- No parameters; widths come from `aes.vh` (`WORD_S`=32, `KEY_S`=128, `BLK_S`=128); command codes are the `SET_KEY`/`ENCRYPT` macros.
- Clock and reset:
  - `clk` in 1: single clock, rising edge.
  - `reset` in 1: asynchronous, active-high reset.
- Upstream AXI-Stream slave:
  - `s_axis_tdata` in 32: input stream data.
  - `s_axis_tvalid` in 1: input stream valid.
  - `s_axis_tready` out 1: input stream ready.
  - `s_axis_tlast` in 1: input stream last.
- Downstream AXI-Stream master:
  - `m_axis_tdata` out 32: output stream data.
  - `m_axis_tvalid` out 1: output stream valid.
  - `m_axis_tready` in 1: output stream ready.
  - `m_axis_tlast` out 1: output stream last.
- Connections to `aes_top`:
  - `aes_en` out 1: drives `en`.
  - `aes_cmd` out [0:31]: drives `aes_cmd`.
  - `aes_key` out [0:127]: drives `aes_key`.
  - `aes_plaintext` out [0:127]: drives `aes_plaintext`.
  - `aes_ciphertext` in [0:127]: from `aes_top`.
  - `aes_en_o` in 1: completion strobe from `aes_top`.

## Operation
- Frame format is 5 words: word 0 is the command, words 1-4 are the payload.
- Payload word k (k=0..3) lands in bits [32k : 32k+31], so the first received word is the MSBs.
- SET_KEY payload loads `aes_key`.
- ENCRYPT payload loads `aes_plaintext`, and `aes_key` is driven all-zero.
- States:
  - IDLE: `s_axis_tready`=1. A beat stores the command word and clears the word counter → RX.
  - RX: `s_axis_tready`=1. Each beat stores a payload word and increments a 2-bit counter.
    - `tlast` on a beat with counter<3: abort and discard → IDLE, no `aes_en`.
    - Beat with counter==3 → START if the command is SET_KEY or ENCRYPT, else → IDLE (frame dropped).
    - `tlast` on the 4th payload word is not checked.
  - START: `aes_en`=1 for exactly this cycle → WAIT.
  - WAIT: `s_axis_tready`=0 and outputs held stable.
    - On `aes_en_o`=1 with SET_KEY → IDLE, no output.
    - On `aes_en_o`=1 with ENCRYPT: latch `aes_ciphertext` into the output shift register → TX.
  - TX: `m_axis_tvalid`=1 and `m_axis_tdata` = ciphertext word j (j=0..3, word 0 = bits [0:31]).
    - The word advances only on `tvalid & tready`.
    - `m_axis_tlast`=1 only on j=3.
    - Handshake on j=3 → IDLE.
- `aes_cmd`, `aes_key` and `aes_plaintext` are registered and change only on accepted RX beats; they hold through START and WAIT.
- Any `aes_en_o` seen outside WAIT is ignored.

## Timing
- Reset value of every output is 0: `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `aes_en`, `aes_cmd`, `aes_key`, `aes_plaintext`. State is IDLE.
- Reset is asynchronous and takes effect immediately in any state, including mid-RX, WAIT and TX.
  - A partial frame is lost.
  - An in-flight `aes_en_o` after reset release is ignored, because the state is IDLE.
- `aes_en` rises on the clock edge after the 4th payload beat is accepted.
- `aes_en` is never high two consecutive cycles.
- `m_axis_tvalid` rises on the clock edge after the cycle in which `aes_en_o` is sampled high in WAIT.
- The 4 output words take 4 cycles minimum with `m_axis_tready` held at 1.
- Under backpressure, `m_axis_tdata`/`m_axis_tlast` stay stable while `tvalid & !tready`.
- `s_axis_tready` is 0 from START through the final TX handshake.
  - The next frame's command word can be accepted on the cycle after the last output handshake, or the cycle after `aes_en_o` for SET_KEY.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Set key:** send SET_KEY, then 54686174 73206d79 204b756e 67204675.
  - Exactly one `aes_en` pulse.
  - `aes_key`=5468617473206d79204b756e67204675.
  - No `m_axis_tvalid` after `aes_en_o`.
- **Encrypt:** send ENCRYPT, then 54776f20 4f6e6520 4e696e65 2054776f.
  - `aes_key`=0.
  - Output words 29c3505f 571420f6 402299b3 1a02d73a, with `tlast` only on the 4th.
- **Encrypt with same key:** send ENCRYPT, then 12345678 91112345 67890123 45678901.
  - Output words 2914b146 6013ba1e 48d6d795 e97d3e15.
- **Backpressure:** repeat the Encrypt case with `m_axis_tready` low 3 cycles before each word.
  - Data and `tlast` stable while stalled; same 4 words out.
  - `s_axis_tready`=0 throughout.
- **Early tlast:** send ENCRYPT with `tlast` on payload word 2.
  - No `aes_en` pulse.
  - The next full SET_KEY frame behaves as in the Set key case.
  - An unknown command frame (e.g. 0xFFFFFFFF) is likewise dropped without `aes_en`.
- **Reset mid-operation:** assert `reset` asynchronously while in WAIT.
  - All outputs 0 immediately.
  - A later `aes_en_o` pulse produces no output.
  - A subsequent Set key + Encrypt sequence yields 29c3505f… correctly.

Source files
------------

// File: rtl/aes_axis_bridge.sv
// aes_axis_bridge: AXI-Stream front end for aes_top. It collects a 5-word command frame,
// fires one aes_en pulse, waits for aes_en_o and streams the ciphertext back as 4 words.
module aes_axis_bridge (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  output logic [31:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic         aes_en,
  output logic [0:31]  aes_cmd,
  output logic [0:127] aes_key,
  output logic [0:127] aes_plaintext,
  input  logic [0:127] aes_ciphertext,
  input  logic         aes_en_o
);
  localparam int WORD_S = 32;
  localparam int KEY_S  = 128;
  localparam int BLK_S  = 128;
  localparam logic [0:WORD_S-1] SET_KEY = 32'h0000_0001;
  localparam logic [0:WORD_S-1] ENCRYPT = 32'h0000_0002;

  typedef enum logic [2:0] {S_IDLE, S_RX, S_START, S_WAIT, S_TX} state_t;

  state_t              r_state, w_state_next;
  logic [1:0]          r_cnt, w_cnt_next;
  logic [0:WORD_S-1]   r_cmd, w_cmd_next;
  logic [0:KEY_S-1]    r_key, w_key_next;
  logic [0:BLK_S-1]    r_pt, w_pt_next;
  logic [0:BLK_S-1]    r_ct, w_ct_next;
  logic                r_s_tready, w_s_tready_next;
  logic                r_m_tvalid, w_m_tvalid_next;
  logic                r_m_tlast, w_m_tlast_next;
  logic [WORD_S-1:0]   r_m_tdata, w_m_tdata_next;
  logic                r_en, w_en_next;

  logic                w_s_beat;
  logic                w_cmd_known;
  logic [1:0]          w_cnt_inc;
  logic [6:0]          w_rx_base;
  logic [6:0]          w_tx_base;

  assign w_s_beat    = r_s_tready & s_axis_tvalid;
  assign w_cmd_known = (r_cmd == SET_KEY) || (r_cmd == ENCRYPT);
  assign w_cnt_inc   = r_cnt + 2'd1;
  // Ascending bit ranges: word k occupies [32k : 32k+31], so word 0 is the MSB word.
  assign w_rx_base   = {r_cnt, 5'd0};
  assign w_tx_base   = {w_cnt_inc, 5'd0};

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_cmd_next      = r_cmd;
    w_key_next      = r_key;
    w_pt_next       = r_pt;
    w_ct_next       = r_ct;
    w_s_tready_next = r_s_tready;
    w_m_tvalid_next = r_m_tvalid;
    w_m_tlast_next  = r_m_tlast;
    w_m_tdata_next  = r_m_tdata;
    w_en_next       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_s_tready_next = 1'b1;
        if (w_s_beat) begin
          w_cmd_next   = s_axis_tdata;
          w_cnt_next   = 2'd0;
          w_state_next = S_RX;
        end
      end
      S_RX: begin
        if (w_s_beat) begin
          if (r_cmd == ENCRYPT) begin
            w_key_next                       = '0;
            w_pt_next[w_rx_base +: WORD_S]   = s_axis_tdata;
          end else if (r_cmd == SET_KEY) begin
            w_key_next[w_rx_base +: WORD_S]  = s_axis_tdata;
          end
          w_cnt_next = w_cnt_inc;
          // tlast is deliberately ignored on the fourth payload word.
          if (r_cnt == 2'd3) begin
            if (w_cmd_known) begin
              w_state_next    = S_START;
              w_en_next       = 1'b1;
              w_s_tready_next = 1'b0;
            end else begin
              w_state_next = S_IDLE;
            end
          end else if (s_axis_tlast) begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_START: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (aes_en_o) begin
          if (r_cmd == ENCRYPT) begin
            w_ct_next       = aes_ciphertext;
            w_m_tdata_next  = aes_ciphertext[0:WORD_S-1];
            w_m_tvalid_next = 1'b1;
            w_m_tlast_next  = 1'b0;
            w_cnt_next      = 2'd0;
            w_state_next    = S_TX;
          end else begin
            w_s_tready_next = 1'b1;
            w_state_next    = S_IDLE;
          end
        end
      end
      S_TX: begin
        if (r_m_tvalid && m_axis_tready) begin
          if (r_cnt == 2'd3) begin
            w_m_tvalid_next = 1'b0;
            w_m_tlast_next  = 1'b0;
            w_m_tdata_next  = '0;
            w_s_tready_next = 1'b1;
            w_state_next    = S_IDLE;
          end else begin
            w_cnt_next      = w_cnt_inc;
            w_m_tdata_next  = r_ct[w_tx_base +: WORD_S];
            w_m_tlast_next  = (w_cnt_inc == 2'd3);
          end
        end
      end
      default: begin
        w_state_next    = S_IDLE;
        w_s_tready_next = 1'b0;
        w_m_tvalid_next = 1'b0;
        w_m_tlast_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_cmd      <= '0;
      r_key      <= '0;
      r_pt       <= '0;
      r_ct       <= '0;
      r_s_tready <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
      r_en       <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_cmd      <= w_cmd_next;
      r_key      <= w_key_next;
      r_pt       <= w_pt_next;
      r_ct       <= w_ct_next;
      r_s_tready <= w_s_tready_next;
      r_m_tvalid <= w_m_tvalid_next;
      r_m_tlast  <= w_m_tlast_next;
      r_m_tdata  <= w_m_tdata_next;
      r_en       <= w_en_next;
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tdata  = r_m_tdata;
  assign aes_en        = r_en;
  assign aes_cmd       = r_cmd;
  assign aes_key       = r_key;
  assign aes_plaintext = r_pt;
endmodule
